// File: rtl/board_pkg.sv
// rtl/board_pkg.sv - board widths, piece code ranges, move status codes, colour helper
package board_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 6;

    localparam logic [DATA_W-1:0] EMPTY = 6'd0;
    localparam logic [DATA_W-1:0] W_MIN = 6'd1;
    localparam logic [DATA_W-1:0] W_MAX = 6'd16;
    localparam logic [DATA_W-1:0] B_MIN = 6'd17;
    localparam logic [DATA_W-1:0] B_MAX = 6'd32;

    typedef enum logic [2:0] {
        OK        = 3'd0,
        ERR_EMPTY = 3'd1,
        ERR_SELF  = 3'd2,
        ERR_SAME  = 3'd3,
        ERR_TURN  = 3'd4
    } move_status_e;

    // Codes above B_MAX are never written here but still count as black.
    function automatic logic is_black(input logic [DATA_W-1:0] code);
        return code >= B_MIN;
    endfunction

endpackage

// File: rtl/board_move_ctrl.sv
// rtl/board_move_ctrl.sv - atomic move sequencer and query arbiter for the board RAM
module board_move_ctrl
    import board_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              mv_valid,
    output logic              mv_ready,
    input  logic [ADDR_W-1:0] mv_from,
    input  logic [ADDR_W-1:0] mv_to,
    output logic              mv_done,
    output logic [2:0]        mv_status,
    output logic [DATA_W-1:0] mv_capt,
    output logic              turn,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_rvalid,
    output logic [DATA_W-1:0] q_rdata,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_SRC, S_CHK_SRC, S_RD_DST, S_CHK_DST,
        S_WR_DST, S_WR_SRC, S_MV_DONE, S_Q_RD, S_Q_DONE
    } state_e;

    state_e            state, state_n;
    logic [ADDR_W-1:0] from_r, to_r, q_addr_r;
    logic [DATA_W-1:0] src_r, dst_r, q_rdata_r;
    logic              rr_last_q;
    move_status_e      status_r, src_status;
    logic              src_err, self_err;
    logic              grant_mv, grant_q;

    // Round robin: on contention, move wins only if the query had the last grant.
    assign grant_mv = mv_valid && (!q_valid || rr_last_q);
    assign grant_q  = q_valid && !grant_mv;

    assign mv_status = status_r;
    assign q_rdata   = (state == S_Q_DONE) ? ram_rdata : q_rdata_r;

    // Source checks in priority order: same square, empty source, wrong side.
    always_comb begin
        src_err    = 1'b1;
        src_status = OK;
        if (from_r == to_r)
            src_status = ERR_SAME;
        else if (ram_rdata == EMPTY)
            src_status = ERR_EMPTY;
        else if (is_black(ram_rdata) != turn)
            src_status = ERR_TURN;
        else
            src_err = 1'b0;
    end

    // Destination may not hold a piece of the side to move.
    always_comb begin
        self_err = (ram_rdata != EMPTY) && (is_black(ram_rdata) == turn);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next state, handshakes and RAM port drive.
    always_comb begin
        state_n   = state;
        mv_ready  = 1'b0;
        q_ready   = 1'b0;
        mv_done   = 1'b0;
        q_rvalid  = 1'b0;
        ram_en    = 1'b0;
        ram_rw    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            S_IDLE: begin
                if (grant_mv) begin
                    mv_ready = 1'b1;
                    state_n  = S_RD_SRC;
                end else if (grant_q) begin
                    q_ready = 1'b1;
                    state_n = S_Q_RD;
                end
            end
            S_RD_SRC: begin
                ram_en   = 1'b1;
                ram_addr = from_r;
                state_n  = S_CHK_SRC;
            end
            S_CHK_SRC: state_n = src_err ? S_MV_DONE : S_RD_DST;
            S_RD_DST: begin
                ram_en   = 1'b1;
                ram_addr = to_r;
                state_n  = S_CHK_DST;
            end
            S_CHK_DST: state_n = self_err ? S_MV_DONE : S_WR_DST;
            S_WR_DST: begin
                ram_en    = 1'b1;
                ram_rw    = 1'b1;
                ram_addr  = to_r;
                ram_wdata = src_r;
                state_n   = S_WR_SRC;
            end
            S_WR_SRC: begin
                ram_en   = 1'b1;
                ram_rw   = 1'b1;
                ram_addr = from_r;
                state_n  = S_MV_DONE;
            end
            S_MV_DONE: begin
                mv_done = 1'b1;
                state_n = S_IDLE;
            end
            S_Q_RD: begin
                ram_en   = 1'b1;
                ram_addr = q_addr_r;
                state_n  = S_Q_DONE;
            end
            S_Q_DONE: begin
                q_rvalid = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Request latching, fetched pieces, result registers (updated on entry to MV_DONE) and turn.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            from_r    <= '0;
            to_r      <= '0;
            q_addr_r  <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            q_rdata_r <= '0;
            rr_last_q <= 1'b1;
            status_r  <= OK;
            mv_capt   <= '0;
            turn      <= 1'b0;
        end else begin
            if (mv_ready) begin
                from_r    <= mv_from;
                to_r      <= mv_to;
                rr_last_q <= 1'b0;
            end
            if (q_ready) begin
                q_addr_r  <= q_addr;
                rr_last_q <= 1'b1;
            end
            if (state == S_CHK_SRC) begin
                src_r <= ram_rdata;
                if (src_err) begin
                    status_r <= src_status;
                    mv_capt  <= '0;
                end
            end
            if (state == S_CHK_DST) begin
                dst_r <= ram_rdata;
                if (self_err) begin
                    status_r <= ERR_SELF;
                    mv_capt  <= '0;
                end
            end
            if (state == S_WR_SRC) begin
                status_r <= OK;
                mv_capt  <= dst_r;
            end
            if (state == S_MV_DONE && status_r == OK)
                turn <= ~turn;
            if (state == S_Q_DONE)
                q_rdata_r <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_board_move_ctrl.sv
// tb/tb_board_move_ctrl.sv - self-checking bench for board_move_ctrl with RAM model and scoreboards
module tb_board_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       mv_valid = 1'b0, mv_ready, mv_done, turn;
    logic [5:0] mv_from = '0, mv_to = '0, mv_capt;
    logic [2:0] mv_status;
    logic       q_valid = 1'b0, q_ready, q_rvalid;
    logic [5:0] q_addr = '0, q_rdata;
    logic       ram_en, ram_rw;
    logic [5:0] ram_addr, ram_wdata;
    logic [5:0] ram_rdata = '0;

    logic       tb_init = 1'b0, tb_wr = 1'b0;
    logic [5:0] tb_addr = '0, tb_data = '0;
    logic [5:0] mem [64];
    logic [5:0] ref_mem [64];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] capt;
    } mexp_t;
    mexp_t      mv_sb[$];
    logic [5:0] q_sb[$];

    typedef struct {
        logic [5:0] from;
        logic [5:0] to;
        logic [2:0] st;
        logic [5:0] capt;
        int         lat;
        logic       turn_after;
    } vec_t;
    vec_t vecs[7];

    board_move_ctrl dut (
        .clk(clk), .reset(reset),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
        .mv_done(mv_done), .mv_status(mv_status), .mv_capt(mv_capt), .turn(turn),
        .q_valid(q_valid), .q_ready(q_ready), .q_addr(q_addr),
        .q_rvalid(q_rvalid), .q_rdata(q_rdata),
        .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] init_code(input int i);
        if (i < 8)                return 6'(9 + i);
        else if (i < 16)          return 6'(i - 7);
        else if (i >= 48 && i < 56) return 6'(17 + i - 48);
        else if (i >= 56)         return 6'(25 + i - 56);
        else                      return 6'd0;
    endfunction

    // Single-port RAM, registered read; bench load/poke ports share the process.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_code(i);
        end else if (tb_wr) begin
            mem[tb_addr] <= tb_data;
        end else if (ram_en) begin
            if (ram_rw) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard consumers.
    always @(negedge clk) begin
        if (mv_done) begin
            chk("mv_sb_nonempty", 32'(mv_sb.size() != 0), 1);
            if (mv_sb.size() != 0) begin
                mexp_t e;
                e = mv_sb.pop_front();
                chk("mv_status", 32'(mv_status), 32'(e.st));
                chk("mv_capt", 32'(mv_capt), 32'(e.capt));
            end
        end
        if (q_rvalid) begin
            chk("q_sb_nonempty", 32'(q_sb.size() != 0), 1);
            if (q_sb.size() != 0) chk("q_rdata", 32'(q_rdata), 32'(q_sb.pop_front()));
        end
    end

    task automatic do_move(input logic [5:0] f, input logic [5:0] t,
                           input logic [2:0] st, input logic [5:0] capt, output int lat);
        int    n;
        mexp_t e;
        @(negedge clk);
        mv_valid = 1'b1; mv_from = f; mv_to = t;
        #1;
        n = 0;
        while (!mv_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("mv_grant_in_time", 32'(n < 50), 1);
        e.st = st; e.capt = capt;
        mv_sb.push_back(e);
        if (st == 3'd0) begin
            ref_mem[t] = ref_mem[f];
            ref_mem[f] = 6'd0;
        end
        @(negedge clk);
        mv_valid = 1'b0;
        lat = 1;
        while (!mv_done && lat < 50) begin @(negedge clk); lat++; end
    endtask

    task automatic do_query(input logic [5:0] a, output int lat);
        int n;
        @(negedge clk);
        q_valid = 1'b1; q_addr = a;
        #1;
        n = 0;
        while (!q_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("q_grant_in_time", 32'(n < 50), 1);
        q_sb.push_back(ref_mem[a]);
        @(negedge clk);
        q_valid = 1'b0;
        lat = 1;
        while (!q_rvalid && lat < 50) begin @(negedge clk); lat++; end
    endtask

    function automatic int ram_diffs();
        int d = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) d++;
        return d;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int  lat;
        int  n;
        string order;

        vecs[0] = '{6'd12, 6'd28, 3'd0, 6'd0,  7, 1'b1};
        vecs[1] = '{6'd1,  6'd2,  3'd4, 6'd0,  3, 1'b1};
        vecs[2] = '{6'd20, 6'd20, 3'd3, 6'd0,  3, 1'b1};
        vecs[3] = '{6'd30, 6'd31, 3'd1, 6'd0,  3, 1'b1};
        vecs[4] = '{6'd57, 6'd49, 3'd2, 6'd0,  5, 1'b1};
        vecs[5] = '{6'd52, 6'd36, 3'd0, 6'd0,  7, 1'b0};
        vecs[6] = '{6'd28, 6'd35, 3'd0, 6'd20, 7, 1'b1};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_code(i);

        reset = 1'b0;
        tb_init = 1'b1;
        repeat (2) @(negedge clk);
        tb_init = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_turn", 32'(turn), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_mv_status", 32'(mv_status), 0);
        chk("rst_q_rdata", 32'(q_rdata), 0);

        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                @(negedge clk);
                tb_wr = 1'b1; tb_addr = 6'd35; tb_data = 6'd20;
                @(negedge clk);
                tb_wr = 1'b0;
                ref_mem[35] = 6'd20;
            end
            do_move(vecs[i].from, vecs[i].to, vecs[i].st, vecs[i].capt, lat);
            chk($sformatf("latency_v%0d", i), 32'(lat), 32'(vecs[i].lat));
            @(negedge clk);
            chk($sformatf("turn_v%0d", i), 32'(turn), 32'(vecs[i].turn_after));
            chk($sformatf("ram_v%0d", i), 32'(ram_diffs()), 0);
        end

        do_query(6'd35, lat);
        chk("q_latency", 32'(lat), 2);
        do_query(6'd28, lat);
        chk("q_latency_empty", 32'(lat), 2);

        // Contention from reset: grants must alternate move, query, move, query.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mv_valid = 1'b1; mv_from = 6'd30; mv_to = 6'd31;
        q_valid = 1'b1;  q_addr = 6'd35;
        order = "";
        n = 0;
        #1;
        while (order.len() < 4 && n < 200) begin
            if (mv_ready) begin
                mexp_t e;
                e.st = 3'd1; e.capt = 6'd0;
                mv_sb.push_back(e);
                order = {order, "M"};
            end
            if (q_ready) begin
                q_sb.push_back(ref_mem[35]);
                order = {order, "Q"};
            end
            @(negedge clk); #1; n++;
        end
        mv_valid = 1'b0; q_valid = 1'b0;
        chk("rr_order", 32'(order == "MQMQ"), 1);
        n = 0;
        while ((mv_sb.size() != 0 || q_sb.size() != 0) && n < 50) begin @(negedge clk); n++; end
        chk("rr_sb_drained", 32'(mv_sb.size() + q_sb.size()), 0);

        // Reset asserted in WR_DST of a legal white move.
        @(negedge clk);
        mv_valid = 1'b1; mv_from = 6'd11; mv_to = 6'd27;
        #1;
        n = 0;
        while (!mv_ready && n < 50) begin @(negedge clk); #1; n++; end
        @(negedge clk);
        mv_valid = 1'b0;
        n = 0;
        while (!(ram_en && ram_rw && ram_addr == 6'd27) && n < 20) begin @(negedge clk); n++; end
        chk("reached_wr_dst", 32'(n < 20), 1);
        reset = 1'b0;
        #1;
        chk("arst_outputs_zero",
            32'({mv_ready, mv_done, mv_status, mv_capt, turn, q_ready, q_rvalid, q_rdata,
                 ram_en, ram_rw, ram_addr, ram_wdata}), 0);
        @(negedge clk);
        reset = 1'b1;
        q_valid = 1'b1; q_addr = 6'd11;
        #1;
        chk("idle_after_reset", 32'(q_ready), 1);
        q_sb.push_back(ref_mem[11]);
        @(negedge clk);
        q_valid = 1'b0;
        n = 0;
        while (!q_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("post_reset_query_seen", 32'(n < 20), 1);
        chk("turn_after_reset", 32'(turn), 0);

        repeat (3) @(negedge clk);
        chk("sb_empty_end", 32'(mv_sb.size() + q_sb.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
